// File: rtl/imm_extend_unit.sv
// Immediate generator for the decode stage.
// Widens an IN_W-bit immediate to OUT_W bits in one of four modes:
// zero, sign, upper or branch-offset.
// Results sit in a DEPTH-entry FIFO behind a valid/ready handshake.
// A tag travels with each entry.

// Pure combinational extender.
// Kept separate so the arithmetic can be read on its own.
module imm_extend_calc #(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int SHAMT_BR = 2
) (
    input  logic [IN_W-1:0]  imm,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] res
);
    localparam int PAD_W = OUT_W - IN_W;

    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] upper;
    logic [OUT_W-1:0] br;

    assign zext  = {{PAD_W{1'b0}}, imm};
    assign sext  = {{PAD_W{imm[IN_W-1]}}, imm};
    assign upper = {imm, {PAD_W{1'b0}}};
    // OUT_W >= IN_W+SHAMT_BR, so the shift never drops significant bits.
    assign br    = sext << SHAMT_BR;

    // Select the extension for the requested mode.
    always_comb begin
        res = zext;
        case (mode)
            2'b00:   res = zext;
            2'b01:   res = sext;
            2'b10:   res = upper;
            2'b11:   res = br;
            default: res = zext;
        endcase
    end
endmodule

module imm_extend_unit #(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int SHAMT_BR = 2,
    parameter int DEPTH    = 2,
    parameter int TAG_W    = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [IN_W-1:0]            in_imm,
    input  logic [1:0]                 in_mode,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_imm,
    output logic [TAG_W-1:0]           out_tag,
    output logic [$clog2(DEPTH):0]     out_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [OUT_W-1:0] mem_imm [DEPTH];
    logic [TAG_W-1:0] mem_tag [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [OUT_W-1:0] ext_imm;
    logic             push;
    logic             pop;

    imm_extend_calc #(
        .IN_W    (IN_W),
        .OUT_W   (OUT_W),
        .SHAMT_BR(SHAMT_BR)
    ) u_calc (
        .imm (in_imm),
        .mode(in_mode),
        .res (ext_imm)
    );

    // Ready depends on held state only.
    // When full, a pop in the same cycle does not open a push slot.
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_imm   = mem_imm[rd_ptr];
    assign out_tag   = mem_tag[rd_ptr];
    assign out_count = count;

    // Storage write.
    // Results are stored already extended.
    // Reset clears every entry, so the head reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_imm[i] <= '0;
                mem_tag[i] <= '0;
            end
        end else if (push) begin
            mem_imm[wr_ptr] <= ext_imm;
            mem_tag[wr_ptr] <= in_tag;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // Occupancy: +1 on push only, -1 on pop only, unchanged otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_imm_extend_unit.sv
// Scoreboard bench for imm_extend_unit.
// Drivers queue hand-computed expected results on acceptance.
// Monitors pop and compare whenever a head entry is consumed.
module tb_imm_extend_unit;
    typedef struct {
        logic [31:0] imm;
        logic [4:0]  tag;
    } exp_t;

    logic        clk = 0;
    logic        rst_n = 0;

    // Default-parameter DUT
    logic        in_valid = 0, in_ready, out_valid, out_ready = 0;
    logic [15:0] in_imm = '0;
    logic [1:0]  in_mode = '0;
    logic [4:0]  in_tag = '0, out_tag;
    logic [31:0] out_imm;
    logic [1:0]  out_count;

    // IN_W=12, SHAMT_BR=1 DUT
    logic        b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 1;
    logic [11:0] b_in_imm = '0;
    logic [1:0]  b_in_mode = '0;
    logic [4:0]  b_in_tag = '0, b_out_tag;
    logic [31:0] b_out_imm;
    logic [1:0]  b_out_count;

    exp_t sb[$];
    exp_t sb2[$];
    int   errors = 0;
    int   checks = 0;
    int   stalls = 0;

    always #5 clk = ~clk;

    imm_extend_unit dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_imm(in_imm), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_tag(out_tag), .out_count(out_count)
    );

    imm_extend_unit #(.IN_W(12), .OUT_W(32), .SHAMT_BR(1), .DEPTH(2), .TAG_W(5)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_imm(b_in_imm), .in_mode(b_in_mode), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_imm(b_out_imm), .out_tag(b_out_tag), .out_count(b_out_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a beat and hold it until accepted.
    // The expected result is queued on the accepting cycle.
    task automatic send(input logic [15:0] imm, input logic [1:0] mode,
                        input logic [4:0] tag, input logic [31:0] exp);
        int n;
        exp_t e;
        n = 0;
        in_valid = 1; in_imm = imm; in_mode = mode; in_tag = tag;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                e.imm = exp; e.tag = tag;
                sb.push_back(e);
                tick();
                break;
            end
            stalls++;
            n++;
            if (n > 50) begin
                checks++; errors++;
                $display("FAIL send_timeout: tag %0d not accepted, expected acceptance", tag);
                break;
            end
        end
        in_valid = 0;
    endtask

    task automatic send2(input logic [11:0] imm, input logic [1:0] mode,
                         input logic [4:0] tag, input logic [31:0] exp);
        int n;
        exp_t e;
        n = 0;
        b_in_valid = 1; b_in_imm = imm; b_in_mode = mode; b_in_tag = tag;
        forever begin
            @(negedge clk);
            if (b_in_ready) begin
                e.imm = exp; e.tag = tag;
                sb2.push_back(e);
                tick();
                break;
            end
            n++;
            if (n > 50) begin
                checks++; errors++;
                $display("FAIL send2_timeout: tag %0d not accepted, expected acceptance", tag);
                break;
            end
        end
        b_in_valid = 0;
    endtask

    // Wait, with a bound, for both scoreboards to empty.
    task automatic drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || sb2.size() != 0) && n < 40) begin
            tick();
            n++;
        end
        check(name, 64'(sb.size() + sb2.size()), 64'd0);
    endtask

    // Monitor for the default DUT
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_out: got imm %0h tag %0d, expected no output", out_imm, out_tag);
            end else begin
                e = sb.pop_front();
                check("out_imm", 64'(out_imm), 64'(e.imm));
                check("out_tag", 64'(out_tag), 64'(e.tag));
            end
        end
    end

    // Monitor for the IN_W=12 DUT
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && b_out_valid && b_out_ready) begin
            if (sb2.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_out2: got imm %0h, expected no output", b_out_imm);
            end else begin
                e = sb2.pop_front();
                check("out_imm2", 64'(b_out_imm), 64'(e.imm));
                check("out_tag2", 64'(b_out_tag), 64'(e.tag));
            end
        end
    end

    initial begin
        // Reset state
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_count", 64'(out_count), 64'd0);
        check("rst_out_imm", 64'(out_imm), 64'd0);
        rst_n = 1;
        tick();
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Modes, default parameters
        out_ready = 1;
        send(16'h7FFF, 2'b00, 5'd1, 32'h00007FFF);
        send(16'h7FFF, 2'b01, 5'd2, 32'h00007FFF);
        send(16'h8000, 2'b01, 5'd3, 32'hFFFF8000);
        send(16'h8000, 2'b10, 5'd4, 32'h80000000);
        send(16'h8000, 2'b11, 5'd5, 32'hFFFE0000);
        send(16'h0001, 2'b11, 5'd6, 32'h00000004);
        drain("drain_modes");

        // Latency and stream
        @(negedge clk);
        check("idle_out_valid", 64'(out_valid), 64'd0);
        tick();
        stalls = 0;
        send(16'h0010, 2'b00, 5'd0, 32'h00000010);
        check("latency_out_valid", 64'(out_valid), 64'd1);
        for (int i = 1; i < 8; i++)
            send(16'(i * 3), 2'b01, 5'(i), 32'(i * 3));
        check("stream_no_stall", 64'(stalls), 64'd0);
        drain("drain_stream");

        // Backpressure, then full with a same-cycle pop
        out_ready = 0;
        send(16'h00A0, 2'b00, 5'd0, 32'h000000A0);
        send(16'hFFFF, 2'b01, 5'd1, 32'hFFFFFFFF);
        check("bp_count_full", 64'(out_count), 64'd2);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        in_valid = 1; in_imm = 16'h1234; in_mode = 2'b10; in_tag = 5'd2;
        tick();
        tick();
        check("bp_held_count", 64'(out_count), 64'd2);
        check("bp_held_ready", 64'(in_ready), 64'd0);
        out_ready = 1;
        @(negedge clk);
        check("full_pop_no_push", 64'(in_ready), 64'd0);
        tick();
        check("after_pop_count", 64'(out_count), 64'd1);
        check("after_pop_ready", 64'(in_ready), 64'd1);
        send(16'h1234, 2'b10, 5'd2, 32'h12340000);
        check("push_pop_count", 64'(out_count), 64'd1);
        drain("drain_bp");
        check("drain_bp_count", 64'(out_count), 64'd0);

        // Asynchronous reset with two entries held
        out_ready = 0;
        send(16'h5555, 2'b00, 5'd9, 32'h00005555);
        send(16'hAAAA, 2'b00, 5'd10, 32'h0000AAAA);
        check("pre_rst_count", 64'(out_count), 64'd2);
        #2 rst_n = 0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_out_imm", 64'(out_imm), 64'd0);
        check("arst_out_tag", 64'(out_tag), 64'd0);
        check("arst_out_count", 64'(out_count), 64'd0);
        sb.delete();
        tick();
        #2 rst_n = 1;
        out_ready = 1;
        tick();
        tick();
        check("post_rst_idle", 64'(out_valid), 64'd0);
        send(16'hC001, 2'b01, 5'd17, 32'hFFFFC001);
        drain("drain_rst");

        // IN_W=12, OUT_W=32, SHAMT_BR=1
        send2(12'h800, 2'b11, 5'd1, 32'hFFFFF000);
        send2(12'h800, 2'b10, 5'd2, 32'h80000000);
        send2(12'h7FF, 2'b11, 5'd3, 32'h00000FFE);
        send2(12'h800, 2'b00, 5'd4, 32'h00000800);
        drain("drain_p12");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Whole-run guard
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
